shift_register_piso_tx: RTL and testbench

//   Parallel-in / serial-out transmitter: the transmit end of the 4-bit serial

---
 rtl/shift_register_piso_tx_if.sv | 32 +++
 rtl/shift_register_piso_tx.sv | 124 ++++++++++++
 tb/tb_shift_register_piso_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_piso_tx_if.sv
// rtl/shift_register_piso_tx_if.sv - load handshake and serial output bundle for the PISO transmitter
interface shift_register_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             data_out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output parallel_in,
    input  load_ready,
    input  data_out,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    output load_ready,
    output data_out,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_register_piso_tx.sv
// rtl/shift_register_piso_tx.sv - parallel-in/serial-out transmitter; PISO_PARITY_EN appends an even-parity bit
module shift_register_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_register_piso_tx_if.slave bus
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   PENULT_IDX = CW'(WIDTH - 2);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  localparam bit PARITY_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             data_out_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_r;
`endif

  // Bit that leaves the word first in the configured direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent; vacated positions fill with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready while idle or on the final frame cycle so frames can abut with no gap.
  assign bus.load_ready = ~reset & ((state == IDLE) | done_r);
  assign accept         = bus.load_valid & bus.load_ready;

  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Frame FSM: the first bit is registered straight from parallel_in at the
  // accept edge, the shift register holds the bits still to be sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      count       <= '0;
      data_out_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else if (accept) begin
      state       <= SHIFT;
      shift_reg   <= shift_word(bus.parallel_in);
      count       <= '0;
      data_out_r  <= first_bit(bus.parallel_in);
      out_valid_r <= 1'b1;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r    <= ^bus.parallel_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (count != LAST_IDX) begin
            data_out_r <= first_bit(shift_reg);
            shift_reg  <= shift_word(shift_reg);
            count      <= count + 1'b1;
            done_r     <= (count == PENULT_IDX) && !PARITY_EN;
          end else begin
`ifdef PISO_PARITY_EN
            state      <= PARITY;
            data_out_r <= parity_r;
            done_r     <= 1'b1;
`else
            state       <= IDLE;
            count       <= '0;
            data_out_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state       <= IDLE;
          count       <= '0;
          data_out_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
`endif
        default: begin
          state       <= IDLE;
          count       <= '0;
          data_out_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// tb/tb_shift_register_piso_tx.sv - scoreboard bench for the PISO transmitter (MSB-first and LSB-first instances)
module tb_shift_register_piso_tx;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = 4 + (PAR ? 1 : 0);

  typedef struct packed {
    logic d;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  exp_t sbq_l[$];

  shift_register_piso_tx_if #(.WIDTH(4)) bus ();
  shift_register_piso_tx_if #(.WIDTH(4)) bus_l ();

  shift_register_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  shift_register_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_l)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every cycle each stream either pops one expected bit or must be idle.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      for (int s = 0; s < 2; s++) begin
        logic ov, d, dn, bz, rd;
        bit   has;
        exp_t e;
        ov  = (s == 0) ? bus.out_valid  : bus_l.out_valid;
        d   = (s == 0) ? bus.data_out   : bus_l.data_out;
        dn  = (s == 0) ? bus.done       : bus_l.done;
        bz  = (s == 0) ? bus.busy       : bus_l.busy;
        rd  = (s == 0) ? bus.load_ready : bus_l.load_ready;
        has = (s == 0) ? (sbq.size() > 0) : (sbq_l.size() > 0);
        n_cmp++;
        if (ov === 1'b1) begin
          if (!has) begin
            n_bad++;
            $display("FAIL s%0d_extra_bit: out_valid=%b required 0 (no bit pending)", s, ov);
          end else begin
            if (s == 0) e = sbq.pop_front();
            else        e = sbq_l.pop_front();
            if (d !== e.d || dn !== e.last || bz !== 1'b1 || rd !== e.last) begin
              n_bad++;
              $display("FAIL s%0d_bit: data_out=%b done=%b busy=%b load_ready=%b required %b %b 1 %b",
                       s, d, dn, bz, rd, e.d, e.last, e.last);
            end
          end
        end else begin
          if (has || ov !== 1'b0 || d !== 1'b0 || dn !== 1'b0 || bz !== 1'b0 || rd !== 1'b1) begin
            n_bad++;
            $display("FAIL s%0d_idle: out_valid=%b data_out=%b done=%b busy=%b load_ready=%b pending=%0b required 0 0 0 0 1 0",
                     s, ov, d, dn, bz, rd, has);
          end
        end
      end
    end
  end

  task automatic push_frame(input bit lsb, input logic [3:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.d    = lsb ? w[i] : w[3-i];
      e.last = (i == 3) && !PAR;
      if (lsb) sbq_l.push_back(e);
      else     sbq.push_back(e);
    end
    if (PAR) begin
      e.d    = ^w;
      e.last = 1'b1;
      if (lsb) sbq_l.push_back(e);
      else     sbq.push_back(e);
    end
  endtask

  task automatic accept_word(input bit lsb, input logic [3:0] w, output int waited);
    logic rdy;
    waited = 0;
    @(negedge clk);
    if (lsb) begin bus_l.load_valid = 1'b1; bus_l.parallel_in = w; end
    else     begin bus.load_valid   = 1'b1; bus.parallel_in   = w; end
    rdy = lsb ? bus_l.load_ready : bus.load_ready;
    while (rdy !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
      rdy = lsb ? bus_l.load_ready : bus.load_ready;
    end
    if (waited >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: load_ready=%b required 1 within 40 cycles", rdy);
    end else begin
      @(posedge clk);
      push_frame(lsb, w);
    end
    #1;
    if (lsb) begin bus_l.load_valid = 1'b0; bus_l.parallel_in = 4'($urandom); end
    else     begin bus.load_valid   = 1'b0; bus.parallel_in   = 4'($urandom); end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() > 0 || sbq_l.size() > 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending=%0d/%0d required 0/0", sbq.size(), sbq_l.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_valid = 1'b0;   bus.parallel_in = 4'h0;
    bus_l.load_valid = 1'b0; bus_l.parallel_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.data_out, bus.out_valid, bus.busy, bus.done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_held: data_out/out_valid/busy/done=%b required 0000",
               {bus.data_out, bus.out_valid, bus.busy, bus.done});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_out, bus.out_valid, bus.busy, bus.done, bus.load_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_release: data_out/out_valid/busy/done/load_ready=%b required 00001",
               {bus.data_out, bus.out_valid, bus.busy, bus.done, bus.load_ready});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    int w;
    accept_word(1'b0, 4'b1011, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    accept_word(1'b0, 4'b1011, w);
    accept_word(1'b0, 4'b0110, w);
    n_cmp++;
    if (w !== FL - 1) begin
      n_bad++;
      $display("FAIL b2b_accept_cycle: waited=%0d required %0d", w, FL - 1);
    end
    drain();
  endtask

  task automatic test_held_valid();
    int w;
    accept_word(1'b0, 4'b1000, w);
    accept_word(1'b0, 4'b1111, w);
    n_cmp++;
    if (w !== FL - 1) begin
      n_bad++;
      $display("FAIL held_accept_cycle: waited=%0d required %0d", w, FL - 1);
    end
    drain();
  endtask

  task automatic test_ignored_load();
    int w;
    accept_word(1'b0, 4'b1100, w);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.parallel_in = 4'b0011;
    @(negedge clk);
    bus.load_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int w;
    accept_word(1'b0, 4'b1011, w);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.data_out, bus.out_valid, bus.busy, bus.done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset: data_out/out_valid/busy/done=%b required 0000",
               {bus.data_out, bus.out_valid, bus.busy, bus.done});
    end
    sbq.delete();
    sbq_l.delete();
    @(negedge clk);
    reset = 1'b0;
    accept_word(1'b0, 4'b0101, w);
    drain();
  endtask

  task automatic test_lsb_first();
    int w;
    accept_word(1'b1, 4'b1011, w);
    drain();
    accept_word(1'b1, 4'b0110, w);
    accept_word(1'b1, 4'b1001, w);
    drain();
  endtask

  task automatic test_random_stream();
    int w;
    for (int k = 0; k < 6; k++) accept_word(1'b0, 4'($urandom), w);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_held_valid();
    test_ignored_load();
    test_reset_mid_frame();
    test_lsb_first();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
